// File: rtl/vib_pkg.sv
// Shared constants for the FFT peak-report path: default sizes, FSM encoding
// and the field positions of the packed complex bin word.
package vib_pkg;
  localparam int LGFFT_DEF = 8;
  localparam int IW_DEF    = 11;

  // A bin word holds the real part in field 1 and the imaginary part in field 0.
  localparam int RE_FIELD = 1;
  localparam int IM_FIELD = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } fsm_state_t;
endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage pipelined exact |re|^2 + |im|^2 of a signed complex bin, carrying
// a valid strobe and an opaque tag alongside the data.
module fft_mag_sq
  import vib_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int TW = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic [TW-1:0]   tag,
  input  logic [2*IW-1:0] data,
  output logic            mag_valid,
  output logic [TW-1:0]   mag_tag,
  output logic [2*IW-1:0] mag
);

  // Squares are computed at 2*IW-1 bits: (-2^(IW-1))^2 = 2^(2*IW-2) still fits unsigned.
  logic signed [2*IW-2:0] re_x_s, im_x_s, re_sq_s, im_sq_s;
  logic        [2*IW-2:0] re_sq_r, im_sq_r;
  logic        [TW-1:0]   tag1_r;
  logic                   valid1_r;

  // Sign-extend both components and square them.
  always_comb begin
    re_x_s  = {{(IW-1){data[RE_FIELD*IW+IW-1]}}, data[RE_FIELD*IW +: IW]};
    im_x_s  = {{(IW-1){data[IM_FIELD*IW+IW-1]}}, data[IM_FIELD*IW +: IW]};
    re_sq_s = re_x_s * re_x_s;
    im_sq_s = im_x_s * im_x_s;
  end

  // Stage 1: register the two squares with their tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_r <= 1'b0;
      tag1_r   <= {TW{1'b0}};
      re_sq_r  <= {(2*IW-1){1'b0}};
      im_sq_r  <= {(2*IW-1){1'b0}};
    end else begin
      valid1_r <= ce;
      if (ce) begin
        tag1_r  <= tag;
        re_sq_r <= re_sq_s;
        im_sq_r <= im_sq_s;
      end
    end
  end

  // Stage 2: one extra bit makes the sum overflow-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_valid <= 1'b0;
      mag_tag   <= {TW{1'b0}};
      mag       <= {(2*IW){1'b0}};
    end else begin
      mag_valid <= valid1_r;
      if (valid1_r) begin
        mag_tag <= tag1_r;
        mag     <= {1'b0, re_sq_r} + {1'b0, im_sq_r};
      end
    end
  end

endmodule

// File: rtl/spectrum_peak_detector.sv
// Frames the FFT output stream, squares each bin and reports the strongest bin
// in the search range once per complete frame; bad frame lengths are flagged.
module spectrum_peak_detector
  import vib_pkg::*;
#(
  parameter int LGFFT         = LGFFT_DEF,
  parameter int IW            = IW_DEF,
  parameter int SKIP_DC       = 1,
  parameter int HALF_SPECTRUM = 1
) (
  input  logic             sys_clock,
  input  logic             reset,
  input  logic             i_ce,
  input  logic             i_sync,
  input  logic [2*IW-1:0]  i_data,
  output logic             o_peak_valid,
  output logic [LGFFT-1:0] o_peak_bin,
  output logic [2*IW-1:0]  o_peak_mag,
  output logic             o_frame_err
);

  localparam int TW = LGFFT + 3;
  localparam logic [LGFFT-1:0] ZERO_IDX = {LGFFT{1'b0}};
  localparam logic [LGFFT-1:0] ONE_IDX  = {{(LGFFT-1){1'b0}}, 1'b1};
  localparam logic [LGFFT-1:0] LAST_IDX = {LGFFT{1'b1}};
  localparam logic [LGFFT-1:0] LO_IDX   = (SKIP_DC != 0) ? ONE_IDX : ZERO_IDX;

  fsm_state_t       state_r, state_nx_s;
  logic [LGFFT-1:0] cnt_r, idx_s;
  logic             accept_s, err_s;
  logic             lo_ok_s, hi_ok_s, in_range_s, first_s, last_s;
  logic [TW-1:0]    tag_s;

  logic             m_valid;
  logic [TW-1:0]    m_tag;
  logic [2*IW-1:0]  m_mag;
  logic [LGFFT-1:0] m_idx;
  logic             m_in_range, m_first, m_last, take_s;

  logic [LGFFT-1:0] best_bin_r;
  logic [2*IW-1:0]  best_mag_r;

  // Frame tracking: decide whether this strobe is accepted and which bin it is.
  always_comb begin
    state_nx_s = state_r;
    idx_s      = cnt_r + ONE_IDX;
    accept_s   = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_ce && i_sync) begin
          accept_s   = 1'b1;
          idx_s      = ZERO_IDX;
          state_nx_s = ST_ACCUM;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (i_ce && i_sync) begin
          accept_s   = 1'b1;
          idx_s      = ZERO_IDX;
          err_s      = (cnt_r != LAST_IDX);
          state_nx_s = ST_ACCUM;
        end else if (i_ce) begin
          accept_s   = 1'b1;
          state_nx_s = (idx_s == LAST_IDX) ? ST_DONE : ST_ACCUM;
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (i_ce && i_sync) begin
          accept_s   = 1'b1;
          idx_s      = ZERO_IDX;
          state_nx_s = ST_ACCUM;
        end else if (i_ce) begin
          err_s      = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, bin counter and the registered frame-error pulse.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= ZERO_IDX;
      o_frame_err <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      o_frame_err <= err_s;
      if (accept_s) begin
        cnt_r <= idx_s;
      end
    end
  end

  // Range flags travel with the sample so the compare stage needs no counter.
  always_comb begin
    lo_ok_s    = (SKIP_DC != 0) ? (idx_s != ZERO_IDX) : 1'b1;
    hi_ok_s    = (HALF_SPECTRUM != 0) ? ~idx_s[LGFFT-1] : 1'b1;
    in_range_s = lo_ok_s & hi_ok_s;
    first_s    = (idx_s == LO_IDX);
    last_s     = (idx_s == LAST_IDX);
    tag_s      = {idx_s, in_range_s, first_s, last_s};
  end

  fft_mag_sq #(
    .IW(IW),
    .TW(TW)
  ) u_mag_sq (
    .clk      (sys_clock),
    .reset    (reset),
    .ce       (accept_s),
    .tag      (tag_s),
    .data     (i_data),
    .mag_valid(m_valid),
    .mag_tag  (m_tag),
    .mag      (m_mag)
  );

  // First in-range bin force-loads, so a stale best from an aborted frame is discarded.
  always_comb begin
    m_idx      = m_tag[TW-1:3];
    m_in_range = m_tag[2];
    m_first    = m_tag[1];
    m_last     = m_tag[0];
    take_s     = m_valid & m_in_range & (m_first | (m_mag > best_mag_r));
  end

  // Stage 3: running best plus a separate result register for the report.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      best_bin_r   <= ZERO_IDX;
      best_mag_r   <= {(2*IW){1'b0}};
      o_peak_valid <= 1'b0;
      o_peak_bin   <= ZERO_IDX;
      o_peak_mag   <= {(2*IW){1'b0}};
    end else begin
      o_peak_valid <= m_valid & m_last;
      if (take_s) begin
        best_bin_r <= m_idx;
        best_mag_r <= m_mag;
      end
      if (m_valid && m_last) begin
        o_peak_bin <= take_s ? m_idx : best_bin_r;
        o_peak_mag <= take_s ? m_mag : best_mag_r;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_peak_detector.sv
// Directed bench for spectrum_peak_detector with LGFFT=4: two instances differ
// only in HALF_SPECTRUM; expected peaks are hand-computed per scenario.
module tb_spectrum_peak_detector;

  localparam int LG = 4;
  localparam int IW = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        sync = 1'b0;
  logic [21:0] data = 22'd0;

  logic        pv, err, pv_f, err_f;
  logic [3:0]  pbin, pbin_f;
  logic [21:0] pmag, pmag_f;

  always #5 clk = ~clk;

  spectrum_peak_detector #(.LGFFT(LG), .IW(IW), .SKIP_DC(1), .HALF_SPECTRUM(1)) dut (
    .sys_clock(clk), .reset(reset), .i_ce(ce), .i_sync(sync), .i_data(data),
    .o_peak_valid(pv), .o_peak_bin(pbin), .o_peak_mag(pmag), .o_frame_err(err)
  );

  spectrum_peak_detector #(.LGFFT(LG), .IW(IW), .SKIP_DC(1), .HALF_SPECTRUM(0)) dut_full (
    .sys_clock(clk), .reset(reset), .i_ce(ce), .i_sync(sync), .i_data(data),
    .o_peak_valid(pv_f), .o_peak_bin(pbin_f), .o_peak_mag(pmag_f), .o_frame_err(err_f)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pv_n = 0, err_n = 0, pv_cyc = 0, err_cyc = 0;
  int last_cyc = 0, sync_cyc = 0;
  int pv0, err0;
  int re_tab[16];
  int im_tab[16];
  logic [3:0] pv_bin_q[$];
  int         pv_mag_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor for the HALF_SPECTRUM=1 instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (pv) begin
      pv_n   <= pv_n + 1;
      pv_cyc <= cyc;
      pv_bin_q.push_back(pbin);
      pv_mag_q.push_back(int'(pmag));
    end
    if (err) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
  end

  task automatic drive(input bit c, input bit s, input int re, input int im);
    int r, i;
    r = re;
    i = im;
    @(negedge clk);
    ce   = c;
    sync = s;
    data = {r[10:0], i[10:0]};
    if (c) last_cyc = cyc;
    if (c && s) sync_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_tab;
    for (int b = 0; b < 16; b++) begin
      re_tab[b] = 0;
      im_tab[b] = 0;
    end
  endtask

  task automatic play_frame(input int gap_max);
    for (int b = 0; b < 16; b++) begin
      if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      drive(1'b1, b == 0, re_tab[b], im_tab[b]);
    end
  endtask

  task automatic snapshot;
    pv0 = pv_n;
    err0 = err_n;
    pv_bin_q.delete();
    pv_mag_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_cmp++; if (pv !== 1'b0)    begin n_bad++; $display("FAIL reset_valid got %b want 0", pv); end
    n_cmp++; if (pbin !== 4'd0)  begin n_bad++; $display("FAIL reset_bin got %0d want 0", pbin); end
    n_cmp++; if (pmag !== 22'd0) begin n_bad++; $display("FAIL reset_mag got %0d want 0", pmag); end
    n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single_tone;
    clear_tab();
    re_tab[3] = 100; im_tab[3] = -50;
    snapshot();
    play_frame(0);
    idle(6);
    n_cmp++; if (pv_n - pv0 !== 1)      begin n_bad++; $display("FAIL tone_count got %0d want 1", pv_n - pv0); end
    n_cmp++; if (pv_cyc - last_cyc !== 3) begin n_bad++; $display("FAIL tone_latency got %0d want 3", pv_cyc - last_cyc); end
    n_cmp++; if (pbin !== 4'd3)         begin n_bad++; $display("FAIL tone_bin got %0d want 3", pbin); end
    n_cmp++; if (pmag !== 22'd12500)    begin n_bad++; $display("FAIL tone_mag got %0d want 12500", pmag); end
    n_cmp++; if (err_n - err0 !== 0)    begin n_bad++; $display("FAIL tone_err got %0d want 0", err_n - err0); end
  endtask

  task automatic test_extremes;
    clear_tab();
    re_tab[0] = -1024; im_tab[0] = -1024;
    re_tab[5] = -1024; im_tab[5] = -1024;
    re_tab[2] = 1023;  im_tab[2] = 1023;
    snapshot();
    play_frame(0);
    idle(6);
    n_cmp++; if (pv_n - pv0 !== 1)     begin n_bad++; $display("FAIL ext_count got %0d want 1", pv_n - pv0); end
    n_cmp++; if (pbin !== 4'd5)        begin n_bad++; $display("FAIL ext_bin got %0d want 5", pbin); end
    n_cmp++; if (pmag !== 22'd2097152) begin n_bad++; $display("FAIL ext_mag got %0d want 2097152", pmag); end
  endtask

  task automatic test_tie_range;
    clear_tab();
    re_tab[2] = 30;   im_tab[2] = 40;
    re_tab[6] = 30;   im_tab[6] = 40;
    re_tab[12] = 500;
    snapshot();
    play_frame(0);
    idle(6);
    n_cmp++; if (pbin !== 4'd2)          begin n_bad++; $display("FAIL tie_bin got %0d want 2", pbin); end
    n_cmp++; if (pmag !== 22'd2500)      begin n_bad++; $display("FAIL tie_mag got %0d want 2500", pmag); end
    n_cmp++; if (pbin_f !== 4'd12)       begin n_bad++; $display("FAIL full_bin got %0d want 12", pbin_f); end
    n_cmp++; if (pmag_f !== 22'd250000)  begin n_bad++; $display("FAIL full_mag got %0d want 250000", pmag_f); end
  endtask

  task automatic test_short_frame;
    clear_tab();
    re_tab[7] = 900;
    snapshot();
    for (int b = 0; b < 9; b++) drive(1'b1, b == 0, re_tab[b], im_tab[b]);
    clear_tab();
    re_tab[4] = 10;
    play_frame(0);
    idle(6);
    n_cmp++; if (err_n - err0 !== 1)        begin n_bad++; $display("FAIL short_err got %0d want 1", err_n - err0); end
    n_cmp++; if (err_cyc - sync_cyc !== 1)  begin n_bad++; $display("FAIL short_err_time got %0d want 1", err_cyc - sync_cyc); end
    n_cmp++; if (pv_n - pv0 !== 1)          begin n_bad++; $display("FAIL short_count got %0d want 1", pv_n - pv0); end
    n_cmp++; if (pbin !== 4'd4)             begin n_bad++; $display("FAIL short_bin got %0d want 4", pbin); end
    n_cmp++; if (pmag !== 22'd100)          begin n_bad++; $display("FAIL short_mag got %0d want 100", pmag); end
  endtask

  task automatic test_long_gapped;
    clear_tab();
    re_tab[6] = -200; im_tab[6] = 150;
    snapshot();
    play_frame(3);
    idle(6);
    n_cmp++; if (pv_n - pv0 !== 1)        begin n_bad++; $display("FAIL gap_count got %0d want 1", pv_n - pv0); end
    n_cmp++; if (pv_cyc - last_cyc !== 3) begin n_bad++; $display("FAIL gap_latency got %0d want 3", pv_cyc - last_cyc); end
    n_cmp++; if (pbin !== 4'd6)           begin n_bad++; $display("FAIL gap_bin got %0d want 6", pbin); end
    n_cmp++; if (pmag !== 22'd62500)      begin n_bad++; $display("FAIL gap_mag got %0d want 62500", pmag); end
    n_cmp++; if (err_n - err0 !== 0)      begin n_bad++; $display("FAIL gap_err got %0d want 0", err_n - err0); end
    drive(1'b1, 1'b0, 0, 0);
    idle(3);
    n_cmp++; if (err_n - err0 !== 1)        begin n_bad++; $display("FAIL long_err got %0d want 1", err_n - err0); end
    n_cmp++; if (err_cyc - last_cyc !== 1)  begin n_bad++; $display("FAIL long_err_time got %0d want 1", err_cyc - last_cyc); end
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 1000, 1000);
    idle(6);
    n_cmp++; if (err_n - err0 !== 1) begin n_bad++; $display("FAIL idle_err got %0d want 1", err_n - err0); end
    n_cmp++; if (pv_n - pv0 !== 1)   begin n_bad++; $display("FAIL idle_count got %0d want 1", pv_n - pv0); end
    clear_tab();
    im_tab[7] = 7;
    play_frame(0);
    idle(6);
    n_cmp++; if (pv_n - pv0 !== 2) begin n_bad++; $display("FAIL resync_count got %0d want 2", pv_n - pv0); end
    n_cmp++; if (pbin !== 4'd7)    begin n_bad++; $display("FAIL resync_bin got %0d want 7", pbin); end
    n_cmp++; if (pmag !== 22'd49)  begin n_bad++; $display("FAIL resync_mag got %0d want 49", pmag); end
  endtask

  task automatic test_reset_mid_frame;
    clear_tab();
    re_tab[3] = 1000;
    snapshot();
    for (int b = 0; b < 9; b++) drive(1'b1, b == 0, re_tab[b], im_tab[b]);
    @(negedge clk);
    ce = 1'b0;
    sync = 1'b0;
    reset = 1'b1;
    idle(2);
    n_cmp++; if (pv !== 1'b0)    begin n_bad++; $display("FAIL midrst_valid got %b want 0", pv); end
    n_cmp++; if (pbin !== 4'd0)  begin n_bad++; $display("FAIL midrst_bin got %0d want 0", pbin); end
    n_cmp++; if (pmag !== 22'd0) begin n_bad++; $display("FAIL midrst_mag got %0d want 0", pmag); end
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    clear_tab();
    im_tab[2] = -60;
    play_frame(0);
    idle(6);
    n_cmp++; if (pv_n - pv0 !== 1)   begin n_bad++; $display("FAIL postrst_count got %0d want 1", pv_n - pv0); end
    n_cmp++; if (pbin !== 4'd2)      begin n_bad++; $display("FAIL postrst_bin got %0d want 2", pbin); end
    n_cmp++; if (pmag !== 22'd3600)  begin n_bad++; $display("FAIL postrst_mag got %0d want 3600", pmag); end
    n_cmp++; if (err_n - err0 !== 0) begin n_bad++; $display("FAIL postrst_err got %0d want 0", err_n - err0); end
  endtask

  task automatic test_back_to_back;
    clear_tab();
    re_tab[1] = 5; im_tab[1] = 5;
    snapshot();
    play_frame(0);
    clear_tab();
    re_tab[7] = 2;
    play_frame(0);
    idle(6);
    n_cmp++; if (pv_n - pv0 !== 2)        begin n_bad++; $display("FAIL b2b_count got %0d want 2", pv_n - pv0); end
    n_cmp++; if (pv_cyc - last_cyc !== 3) begin n_bad++; $display("FAIL b2b_latency got %0d want 3", pv_cyc - last_cyc); end
    n_cmp++; if (err_n - err0 !== 0)      begin n_bad++; $display("FAIL b2b_err got %0d want 0", err_n - err0); end
    if (pv_bin_q.size() != 2) begin
      n_cmp++; n_bad++;
      $display("FAIL b2b_results got %0d results want 2", pv_bin_q.size());
    end else begin
      n_cmp++; if (pv_bin_q[0] !== 4'd1) begin n_bad++; $display("FAIL b2b_bin_a got %0d want 1", pv_bin_q[0]); end
      n_cmp++; if (pv_mag_q[0] !== 50)   begin n_bad++; $display("FAIL b2b_mag_a got %0d want 50", pv_mag_q[0]); end
      n_cmp++; if (pv_bin_q[1] !== 4'd7) begin n_bad++; $display("FAIL b2b_bin_b got %0d want 7", pv_bin_q[1]); end
      n_cmp++; if (pv_mag_q[1] !== 4)    begin n_bad++; $display("FAIL b2b_mag_b got %0d want 4", pv_mag_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_extremes();
    test_tie_range();
    test_short_frame();
    test_long_gapped();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_detector.md
Name: spectrum_peak_detector

Overview:
- Consumes the fftmain output stream: one complex bin per sample strobe, frame sync on bin 0.
- Computes the exact signed magnitude-squared of each bin and finds the peak bin within a configurable search range.
- Reports the peak bin and its magnitude once per complete frame; malformed frames are flagged.
- Sits directly downstream of the FFT, in parallel with UARTDriver; drives the LED/UART peak report.

Parameters:
- LGFFT, 8, log2 of FFT length; FFT_LEN = 2**LGFFT.
- IW, 11, signed width of each real/imag component.
- SKIP_DC, 1, when 1, bin 0 is excluded from the search.
- HALF_SPECTRUM, 1, when 1, only bins below FFT_LEN/2 are searched (real input, symmetric spectrum).

Ports:
- sys_clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_ce  in  1  one FFT bin is valid this cycle.
- i_sync  in  1  high with i_ce on bin 0 of a frame; ignored when i_ce is low.
- i_data  in  2*IW  bin value: [2*IW-1:IW] signed real, [IW-1:0] signed imaginary.
- o_peak_valid  out  1  one-cycle pulse: a new peak result is on the outputs.
- o_peak_bin  out  LGFFT  index of the peak bin.
- o_peak_mag  out  2*IW  unsigned re^2 + im^2 of the peak bin.
- o_frame_err  out  1  one-cycle pulse: frame-length violation detected.

Behaviour:
- Reset: all outputs 0, state IDLE, pipeline valids cleared, bin counter 0, best registers 0. Reset mid-frame discards the frame; no o_peak_valid follows.
- Arithmetic, fully signed:
  - Stage 1 registers re*re and im*im, each 2*IW-1 bits unsigned.
  - Stage 2 registers their sum, 2*IW bits, with no overflow. Maximum is 2*(2^(IW-1))^2 = 2^(2*IW-1).
  - Bin index, in-range flag, first-in-range flag and last-bin flag travel with the data through both stages.
- FSM states:
  - IDLE:
    - i_ce & i_sync: accept as bin 0, go to ACCUM.
    - i_ce & ~i_sync: drop the sample; no error.
  - ACCUM:
    - i_ce & ~i_sync: bin++, sample accepted.
    - i_ce & i_sync with bin counter < FFT_LEN-1: o_frame_err pulses the next cycle and the sample restarts as bin 0; stay in ACCUM.
    - On acceptance of bin FFT_LEN-1: go to DONE.
  - DONE:
    - i_ce & i_sync: new frame bin 0, go to ACCUM.
    - i_ce & ~i_sync: o_frame_err pulses, go to IDLE.
    - No i_ce: stay.
- Search range:
  - Lower bound LO = SKIP_DC.
  - Upper bound HI = HALF_SPECTRUM ? FFT_LEN/2-1 : FFT_LEN-1.
  - Out-of-range bins are counted but never compared.
- Compare stage (stage 3):
  - A first-in-range bin force-loads the best registers, which also clears stale state from an aborted frame.
  - Otherwise best is updated only if mag > best (strictly greater). Ties keep the lower bin index.
- Result timing:
  - Let the i_ce carrying bin FFT_LEN-1 be at cycle t. Then o_peak_valid = 1 exactly in cycle t+3.
  - o_peak_bin and o_peak_mag are updated at that same edge, using the final compare including bin HI.
  - Outputs hold until the next result.
- All-zero spectrum: o_peak_bin = LO, o_peak_mag = 0.
- Back-to-back frames (i_ce every cycle): sustained with no bubbles. The next frame's force-load in stage 3 never collides with the last-bin report because result registers are separate from the best registers.
- o_frame_err and o_peak_valid may never assert for the same frame.

Decomposition:
- Shared package vib_pkg holds:
  - LGFFT, IW defaults.
  - FSM state encoding (IDLE, ACCUM, DONE).
  - Bin data field slicing constants (real/imag offsets).
- Sub-module fft_mag_sq: 2-stage pipelined signed magnitude-squared with valid/tag passthrough. It is reusable to replace the combinational UART_data computation at top level.

Test Plan (LGFFT=4, IW=11, SKIP_DC=1, HALF_SPECTRUM=1 unless noted):
- Single tone:
  - Stimulus: frame with bin 3 = (re 100, im -50), all other bins 0, i_ce every cycle.
  - Response: o_peak_valid at t+3 after bin 15, o_peak_bin=3, o_peak_mag=12500, o_frame_err never high.
- Extremes and DC exclusion:
  - Stimulus: bin 0 = (-1024,-1024), bin 5 = (-1024,-1024), bin 2 = (1023,1023).
  - Response: peak bin 5, mag 2097152.
- Tie and range:
  - Stimulus: bins 2 and 6 both (30,40); bin 12 = (500,0) with HALF_SPECTRUM=1.
  - Response: peak bin 2, mag 2500.
  - Rerun with HALF_SPECTRUM=0: peak bin 12, mag 250000.
- Short frame:
  - Stimulus: sync reasserted at bin count 9, then a full good frame with bin 4 = (10,0).
  - Response: one o_frame_err pulse, no o_peak_valid for the aborted frame, next result bin 4, mag 100.
- Long frame and gapped i_ce:
  - Stimulus: frame with random i_ce gaps, then a 17th sample without sync.
  - Response: correct peak reported, then o_frame_err, FSM in IDLE, samples ignored until the next sync.
- Reset mid-frame:
  - Stimulus: assert reset at bin 8, release, send one full frame.
  - Response: outputs 0 during reset, exactly one o_peak_valid, for the post-reset frame only.
